cmp: RTL and testbench
======================

// Module: cmp
// PURPOSE
//  4-bit domino-style equality comparator, modelled in synthesizable RTL.
//  Clock-phased like dynamic logic: clk low = PRECHARGE (output forced low),
//  clk high = EVALUATE (output reports A==B).
//  Leaf datapath block, used wherever a fast clocked match flag is needed
//  (tag or key compare).
// PARAMETERS
//  WIDTH  4  operand width in bits. The design is verified only at 4.
// PORTS
//  clk  in   1      single clock. Low phase = precharge, high phase = evaluate.
//  rst  in   1      asynchronous, active-high reset.
//  A    in   WIDTH  operand A. Must be stable at posedge clk.
//  B    in   WIDTH  operand B. Must be stable at posedge clk.
//  out  out  1      match flag. 1 only while clk is high and the sampled A==B.
// BEHAVIOUR
//  - Reset: while rst=1, eq_q=0 and out=0 immediately, regardless of clk.
//  - Sampling: at each posedge clk with rst=0, eq_q <= &(A ~^ B).
//    Only this posedge sample is used.
//  - Output: out = clk & eq_q & ~rst. The output is combinational from clk
//    and registered state. It is never driven combinationally from A or B.
//  - Precharge phase (clk=0): out=0 unconditionally. Inputs may change freely.
//  - Evaluate phase (clk=1): out holds the posedge result for the whole high
//    phase (monotonic). Input changes during evaluate have no effect until
//    the next posedge.
//  - Latency: out is valid in the same high phase as the capturing posedge.
//  - Reset released mid-high-phase: out stays 0 until the next posedge sample.
//  - Reset asserted mid-evaluate: out drops to 0 asynchronously.
//  - X or Z on A or B at the sampling edge: do not care. No X-pessimism
//    handling is required.
//  - No handshake, no backpressure. One comparison per clock cycle.
// STRUCTURE
//  - No shared package is needed. WIDTH is a local parameter default only.
//  - Sub-module cmp_bit_eq: 1-bit XNOR cell (a, b -> eq). Instantiate WIDTH
//    copies via generate, then AND-reduce in a balanced tree of 2-input
//    stages, mirroring the domino pull-down network.
//  - Top level holds: the generate array, the reduction tree, the
//    async-reset eq_q flop, and the clk-gated output AND.
// TESTING
//  - Run with a 2 ns clk period, clk starting at 0. Change inputs only while
//    clk is low. Check out in the high phase and in the low phase.
//  - rst=1, A=1010, B=1010, clk toggling
//      -> out=0 throughout. Release rst -> out=1 from the first high phase on.
//  - A=1001, B=1010
//      -> out=0 in both phases.
//  - A=1011, B=1100 (A<B)
//      -> out=0.
//      -> Then A=1011, B=1011 -> out=1 in the next high phase, 0 in the low phase.
//  - A=1100, B=1010 (A>B)
//      -> out=0.
//      -> Change B to 1100 mid-high-phase: out stays 0 until the next posedge,
//         then goes to 1.
//  - A=B=1111, out=1 in evaluate, then assert rst mid-high-phase
//      -> out=0 immediately. Stays 0 until rst is released and a posedge occurs.
//  - Sweep all 256 A/B pairs, one pair per cycle
//      -> out = (A==B) during every high phase, and 0 during every low phase.

Source files
------------

// File: rtl/cmp_bit_eq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : cmp_bit_eq                                                  |
// | Brief  : 1-bit equality cell (XNOR). One leaf of the compare network.|
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module cmp_bit_eq (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = a ~^ b;

endmodule
`default_nettype wire

// File: rtl/cmp.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : cmp                                                         |
// | Brief  : Clock-phased (domino-style) equality comparator. Low phase  |
// |          precharges the flag to 0, high phase reports the A==B       |
// |          result sampled at the rising edge.                          |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module cmp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out
);

  // Reduction tree is built over the next power of two; unused leaves are
  // tied to 1 so they never spoil a match.
  localparam int c_LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int c_LEAVES = 1 << c_LEVELS;
  localparam int c_NODES  = 2 * c_LEAVES - 1;

  // Heap-ordered tree: node n has children 2n+1 and 2n+2, root is node 0,
  // leaves occupy the top c_LEAVES entries.
  logic [c_NODES-1:0] w_node;
  logic               r_eq;

  genvar gi;

  generate
    for (gi = 0; gi < c_LEAVES; gi++) begin : g_leaf
      if (gi < WIDTH) begin : g_cell
        cmp_bit_eq u_bit_eq (
          .a  (A[gi]),
          .b  (B[gi]),
          .eq (w_node[c_LEAVES-1+gi])
        );
      end else begin : g_pad
        assign w_node[c_LEAVES-1+gi] = 1'b1;
      end
    end

    for (gi = 0; gi < c_LEAVES - 1; gi++) begin : g_tree
      assign w_node[gi] = w_node[2*gi+1] & w_node[2*gi+2];
    end
  endgenerate

  // Capture the match result once per cycle on the evaluate edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eq <= 1'b0;
    end else begin
      r_eq <= w_node[0];
    end
  end

  // Evaluate gate: the flag is only visible while clk is high and out of reset.
  assign out = clk & r_eq & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_cmp.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module : tb_cmp                                                      |
// | Brief  : Directed self-checking bench for the clock-phased comparator|
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_cmp;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       out;

  int n_checks = 0;
  int n_fail   = 0;

  cmp #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .out (out)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One full cycle from the low phase: check high phase, then low phase.
  task automatic step(input string tag, input logic exp_hi);
    @(posedge clk);
    #0.5 check({tag, "_hi"}, out, exp_hi);
    @(negedge clk);
    #0.5 check({tag, "_lo"}, out, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    A   = 4'b1010;
    B   = 4'b1010;
    #0.5 check("reset_t0", out, 1'b0);

    // Held in reset with equal operands: flag must stay low.
    for (int i = 0; i < 3; i++) step("in_reset", 1'b0);

    // Release in the low phase: first high phase reports the match.
    rst = 1'b0;
    step("rel_first", 1'b1);
    step("rel_second", 1'b1);

    A = 4'b1001; B = 4'b1010;
    step("ne_1001_1010", 1'b0);

    A = 4'b1011; B = 4'b1100;
    step("lt_1011_1100", 1'b0);
    B = 4'b1011;
    step("eq_1011", 1'b1);

    // B changes during evaluate: ignored until the next rising edge.
    A = 4'b1100; B = 4'b1010;
    @(posedge clk);
    #0.3 check("gt_before_chg", out, 1'b0);
    B = 4'b1100;
    #0.2 check("gt_after_chg", out, 1'b0);
    @(negedge clk);
    #0.5 check("gt_chg_lo", out, 1'b0);
    step("gt_next_edge", 1'b1);

    // Reset asserted mid-evaluate drops the flag immediately.
    A = 4'b1111; B = 4'b1111;
    @(posedge clk);
    #0.3 check("ones_eval", out, 1'b1);
    rst = 1'b1;
    #0.1 check("rst_mid_eval", out, 1'b0);
    @(negedge clk);
    #0.5 check("rst_mid_lo", out, 1'b0);
    step("rst_hold", 1'b0);
    rst = 1'b0;
    step("rst_release", 1'b1);

    // Reset released mid-high-phase: flag stays low until the next sample.
    rst = 1'b1;
    @(posedge clk);
    #0.3 check("rel_mid_pre", out, 1'b0);
    rst = 1'b0;
    #0.2 check("rel_mid_post", out, 1'b0);
    @(negedge clk);
    #0.5 check("rel_mid_lo", out, 1'b0);
    step("rel_mid_next", 1'b1);

    // Exhaustive sweep, one pair per cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        step($sformatf("sweep_%0d_%0d", a, b), (a == b) ? 1'b1 : 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
